// File: rtl/pout_byte_serializer.sv
// pout_byte_serializer: 16-bit word FIFO drained as two bytes per word over a valid/ready pad link.
// Define POUT_MSB_FIRST_EN to present the high byte first (default: low byte first).
module pout_byte_serializer #(
   parameter int DEPTH = 4
) (
   input  logic                      clock,
   input  logic                      resetb,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [15:0]               in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [7:0]                out_data,
   output logic [15:0]               words_sent,
   output logic [$clog2(DEPTH):0]    fifo_level
);
   localparam int AW = $clog2(DEPTH);

   logic [15:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   level_q, level_d;
   logic          phase_q, phase_d;
   logic [15:0]   sent_q, sent_d;
   logic          push, xfer, pop, hi_sel;
   logic [15:0]   head;

   assign in_ready   = level_q != (AW+1)'(DEPTH);
   assign out_valid  = level_q != '0;
   assign fifo_level = level_q;
   assign words_sent = sent_q;
   assign push = in_valid && in_ready;
   assign xfer = out_valid && out_ready;
   assign pop  = xfer && phase_q;
   assign head = mem_q[rd_q];
`ifdef POUT_MSB_FIRST_EN
   assign hi_sel = ~phase_q;
`else
   assign hi_sel = phase_q;
`endif
   // Gated so the pad reads 0x00 whenever nothing is stored, including after reset.
   assign out_data = out_valid ? (hi_sel ? head[15:8] : head[7:0]) : 8'h00;

   always_comb begin
      wr_d    = push ? wr_q + 1'b1 : wr_q;
      rd_d    = pop ? rd_q + 1'b1 : rd_q;
      level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
      phase_d = xfer ? ~phase_q : phase_q;
      sent_d  = pop ? sent_q + 16'd1 : sent_q;
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_q] <= in_data;
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
         phase_q <= 1'b0;
         sent_q  <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
         phase_q <= phase_d;
         sent_q  <= sent_d;
      end
   end
endmodule

// File: tb/tb_pout_byte_serializer.sv
// tb_pout_byte_serializer: randomized bench with a queue-based word/byte reference model.
module tb_pout_byte_serializer;
   localparam int DEPTH = 4;
`ifdef POUT_MSB_FIRST_EN
   localparam bit MSB = 1'b1;
`else
   localparam bit MSB = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        resetb = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data;
   logic [15:0] words_sent;
   logic [2:0]  fifo_level;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] mq[$];
   int          bi = 0;
   logic [15:0] ws_m = '0;

   pout_byte_serializer #(.DEPTH(DEPTH)) dut (
      .clock(clock), .resetb(resetb), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .words_sent(words_sent), .fifo_level(fifo_level)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] first_b(input logic [15:0] w);
      return MSB ? w[15:8] : w[7:0];
   endfunction

   function automatic logic [7:0] second_b(input logic [15:0] w);
      return MSB ? w[7:0] : w[15:8];
   endfunction

   function automatic logic [7:0] exp_byte();
      if (mq.size() == 0) return 8'h00;
      return bi == 0 ? first_b(mq[0]) : second_b(mq[0]);
   endfunction

   function automatic void model_reset();
      mq.delete();
      bi = 0;
      ws_m = '0;
   endfunction

   // Advances one clock and applies the handshakes seen by that edge to the model.
   task automatic tick();
      bit push, pop;
      @(posedge clock);
      push = in_valid && (mq.size() < DEPTH);
      pop  = (mq.size() > 0) && out_ready;
      if (pop) begin
         if (bi == 1) begin
            void'(mq.pop_front());
            ws_m = ws_m + 16'd1;
            bi = 0;
         end else bi = 1;
      end
      if (push) mq.push_back(in_data);
      @(negedge clock);
   endtask

   task automatic test_reset();
      resetb = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clock);
      model_reset();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_vec++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", fifo_level); end
      n_vec++; if (words_sent !== 16'd0) begin n_err++; $display("FAIL reset_words_sent got %0d want 0", words_sent); end
      n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got %h want 00", out_data); end
      @(negedge clock);
      resetb = 1'b1;
      tick();
      n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL post_reset_out_data got %h want 00", out_data); end
   endtask

   task automatic test_single();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
      tick();
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", out_valid); end
      n_vec++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL single_level got %0d want 1", fifo_level); end
      n_vec++; if (out_data !== (MSB ? 8'h12 : 8'h34)) begin n_err++; $display("FAIL single_b0 got %h want %h", out_data, MSB ? 8'h12 : 8'h34); end
      tick();
      n_vec++; if (out_data !== (MSB ? 8'h34 : 8'h12)) begin n_err++; $display("FAIL single_b1 got %h want %h", out_data, MSB ? 8'h34 : 8'h12); end
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", out_valid); end
      n_vec++; if (words_sent !== 16'd1 || ws_m !== 16'd1) begin n_err++; $display("FAIL single_words got %0d want 1", words_sent); end
   endtask

   task automatic test_full();
      logic [15:0] w[4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = w[i];
         tick();
      end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %b want 0", in_ready); end
      n_vec++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL full_level got %0d want 4", fifo_level); end
      in_data = 16'hEEEE;
      tick();
      in_valid = 1'b0;
      n_vec++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL full_overflow_level got %0d want 4", fifo_level); end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if (out_valid !== 1'b1 || out_data !== w[i/2][7:0]) begin
            n_err++; $display("FAIL full_byte%0d got %b/%h want 1/%h", i, out_valid, out_data, w[i/2][7:0]);
         end
         tick();
      end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_drain got %b want 0 (extra word)", out_valid); end
   endtask

   task automatic test_stall();
      logic [3:0] rdy = 4'b1001;
      logic [7:0] exp_b[4];
      exp_b = '{first_b(16'h0102), second_b(16'h0102), second_b(16'h0102), second_b(16'h0102)};
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0102;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         out_ready = rdy[3-i];
         n_vec++;
         if (out_valid !== 1'b1 || out_data !== exp_b[i]) begin
            n_err++; $display("FAIL stall_c%0d got %b/%h want 1/%h", i, out_valid, out_data, exp_b[i]);
         end
         tick();
      end
      n_vec++; if (out_valid !== 1'b0 || words_sent !== ws_m) begin n_err++; $display("FAIL stall_end got %b/%0d want 0/%0d", out_valid, words_sent, ws_m); end
   endtask

   task automatic test_stream();
      logic [7:0]  rx[$];
      logic [15:0] ws0;
      int nxt = 0, cyc = 0, bad = 0;
      ws0 = ws_m;
      while ((nxt < 1024 || mq.size() > 0) && cyc < 20000) begin
         in_valid  = (nxt < 1024) && ($urandom_range(3) != 0);
         in_data   = 16'(nxt);
         out_ready = $urandom_range(2) != 0;
         n_vec++;
         if (out_valid !== (mq.size() > 0) || out_data !== exp_byte() || in_ready !== (mq.size() < DEPTH)
             || fifo_level !== 3'(mq.size()) || words_sent !== ws_m) begin
            n_err++;
            if (bad++ < 10) $display("FAIL stream_c%0d got v%b d%h r%b l%0d w%0d want v%b d%h r%b l%0d w%0d", cyc,
               out_valid, out_data, in_ready, fifo_level, words_sent,
               mq.size() > 0, exp_byte(), mq.size() < DEPTH, mq.size(), ws_m);
         end
         if (out_valid && out_ready) rx.push_back(out_data);
         if (in_valid && mq.size() < DEPTH) nxt++;
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      n_vec++; if (cyc >= 20000) begin n_err++; $display("FAIL stream_timeout got %0d words want 1024", nxt); end
      n_vec++; if (rx.size() != 2048) begin n_err++; $display("FAIL stream_bytes got %0d want 2048", rx.size()); end
      bad = 0;
      for (int i = 0; i + 1 < rx.size(); i += 2) begin
         logic [15:0] w;
         w = MSB ? {rx[i], rx[i+1]} : {rx[i+1], rx[i]};
         n_vec++;
         if (w !== 16'(i/2)) begin
            n_err++;
            if (bad++ < 10) $display("FAIL stream_word%0d got %h want %h", i/2, w, 16'(i/2));
         end
      end
      n_vec++; if (words_sent !== ws0 + 16'd1024) begin n_err++; $display("FAIL stream_words got %0d want %0d", words_sent, ws0 + 16'd1024); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h5678;
      tick();
      in_valid = 1'b0;
      tick();
      n_vec++; if (out_data !== second_b(16'h5678)) begin n_err++; $display("FAIL mid_high got %h want %h", out_data, second_b(16'h5678)); end
      resetb = 1'b0;
      #1;
      model_reset();
      n_vec++; if (out_valid !== 1'b0 || fifo_level !== 3'd0 || words_sent !== 16'd0 || out_data !== 8'h00) begin
         n_err++; $display("FAIL mid_reset got v%b l%0d w%0d d%h want v0 l0 w0 d00", out_valid, fifo_level, words_sent, out_data);
      end
      @(negedge clock);
      @(negedge clock);
      resetb = 1'b1;
      in_valid = 1'b1; in_data = 16'h9ABC;
      tick();
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b1 || out_data !== first_b(16'h9ABC)) begin n_err++; $display("FAIL mid_b0 got %b/%h want 1/%h", out_valid, out_data, first_b(16'h9ABC)); end
      tick();
      n_vec++; if (out_data !== second_b(16'h9ABC)) begin n_err++; $display("FAIL mid_b1 got %h want %h", out_data, second_b(16'h9ABC)); end
      tick();
      n_vec++; if (out_valid !== 1'b0 || words_sent !== 16'd1) begin n_err++; $display("FAIL mid_end got %b/%0d want 0/1", out_valid, words_sent); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_stall();
      test_stream();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
